voter_seq: RTL and testbench
============================

# voter_seq

Sequential, parametrised ballot voter that supersedes the fixed 3-input combinational majority voter. It opens a timed voting window for N_VOTERS voters, latches each voter's first valid yes/no vote, and closes early once every voter has voted. It then tallies the ballots against one of four selectable pass rules and holds the result until the next ballot. It sits between the debounced push-button inputs and the display/LED result logic of the board design.

## Interface
- N_VOTERS, 7, number of voters (1..31)
- WINDOW, 1000, voting window length in clock cycles (>= 2)
- TW, 16, timer width; WINDOW must be < 2^TW
- CW (localparam), $clog2(N_VOTERS+1), count width
---
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  open a new ballot (level sampled per cycle)
- mode  input  2  pass rule, latched at start: 0 simple, 1 absolute, 2 two-thirds, 3 unanimous
- vote_yes  input  N_VOTERS  per-voter yes request, one-cycle pulse or level
- vote_no  input  N_VOTERS  per-voter no request
- busy  output  1  high in VOTING and TALLY
- done  output  1  one-cycle pulse on entry to RESULT
- pass  output  1  ballot result, valid from done until next start
- yes_cnt  output  CW  yes votes recorded
- no_cnt  output  CW  no votes recorded
- abstain_cnt  output  CW  voters with no recorded vote

## Operation
- States: IDLE, VOTING, TALLY, RESULT; reset -> IDLE.
- IDLE/RESULT + start=1: next cycle VOTING; voted/ballot registers cleared, timer=0, mode latched. In RESULT, outputs pass/counts clear on that same edge.
- start in VOTING or TALLY: ignored.
- VOTING, per voter i not yet voted: vote_yes[i]^vote_no[i]=1 -> record voted[i]=1, ballot[i]=vote_yes[i]. Both high or both low -> nothing recorded this cycle; voter may vote later. Once voted, further requests are ignored (no revote).
- Window close: timer==WINDOW-1, or all voters voted including this cycle's updates -> TALLY. Votes presented on the closing cycle are counted.
- TALLY (1 cycle): popcount yes=Σ(voted&ballot), no=Σ(voted&~ballot), abstain=N_VOTERS-yes-no; register counts and pass; -> RESULT.
- Pass rules, with all arithmetic in CW+2 bits unsigned:
  - mode 0: yes > no. A tie fails; all abstain fails.
  - mode 1: 2*yes > N_VOTERS.
  - mode 2: 3*yes >= 2*N_VOTERS.
  - mode 3: yes == N_VOTERS.
- RESULT: hold pass/counts; done high only on the first RESULT cycle; stay until start.
- Reset (rst_n=0 at edge) in any state, including mid-VOTING: state IDLE; busy, done, pass, all counts, timer, voted, and ballot go to 0. The ballot in progress is discarded.

## Timing
- All outputs registered; reset values all 0.
- start at edge k -> busy=1 from k+1.
- Full window: VOTING occupies cycles k+1..k+WINDOW; TALLY at k+WINDOW+1; done/pass valid at k+WINDOW+2.
- Early close: last vote recorded at edge m -> TALLY at m+1, done at m+2.
- Minimum ballot (all vote on the first VOTING cycle): start to done = 3 cycles.
- busy falls on the same edge that done rises.
- No combinational path from inputs to outputs.

## Test plan
- Reset: assert rst_n=0 for 2 cycles during VOTING -> IDLE; all outputs 0; no done pulse.
- N=7, mode 0: votes yes from voters 0,1,2, no from 3,4, none from 5,6; window expires -> done at start+WINDOW+2, yes=3, no=2, abstain=2, pass=1. Rerun with yes=2 and no=2 -> pass=0.
- Early close: all 7 voters pulse on the same cycle (4 yes, 3 no) -> done exactly 3 cycles after start; mode 1 pass=1; mode 2 (4*3=12 < 14) pass=0.
- Revote/conflict: voter 0 drives yes and no together (not recorded), then no, then yes -> recorded as no; no_cnt includes it.
- Mode 3: 6 yes plus 1 abstain -> pass=0; 7 yes -> pass=1, early close.
- start pulsed mid-VOTING is ignored (timing unchanged). start in RESULT clears counts and opens a new window; mode change while VOTING has no effect.

Source files
------------

// File: rtl/voter_seq.sv
// Timed ballot voter: latches each voter's first valid yes/no vote during a window,
// then tallies against a selectable pass rule and holds the result until the next ballot.
module voter_seq #(
    parameter int unsigned N_VOTERS = 7,
    parameter int unsigned WINDOW   = 1000,
    parameter int unsigned TW       = 16,
    localparam int unsigned CW      = $clog2(N_VOTERS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [N_VOTERS-1:0] vote_yes,
    input  logic [N_VOTERS-1:0] vote_no,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [CW-1:0]       yes_cnt,
    output logic [CW-1:0]       no_cnt,
    output logic [CW-1:0]       abstain_cnt
);

    localparam int unsigned PW = CW + 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VOTING = 2'd1,
        TALLY  = 2'd2,
        RESULT = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [N_VOTERS-1:0]   voted_q, voted_d;
    logic [N_VOTERS-1:0]   ballot_q, ballot_d;
    logic [1:0]            mode_q, mode_d;
    logic                  busy_d, done_d, pass_d;
    logic [CW-1:0]         yes_d, no_d, abstain_d;

    logic [N_VOTERS-1:0]   valid_c;
    logic [N_VOTERS-1:0]   voted_upd_c;
    logic [N_VOTERS-1:0]   ballot_upd_c;
    logic [CW-1:0]         yes_sum_c, no_sum_c;
    logic                  rule_c;

    // Exactly one of yes/no from a voter who has not yet voted is a valid vote
    always_comb begin
        valid_c      = (vote_yes ^ vote_no) & ~voted_q;
        voted_upd_c  = voted_q | valid_c;
        ballot_upd_c = (ballot_q & ~valid_c) | (valid_c & vote_yes);
    end

    // Popcount of recorded ballots
    always_comb begin
        yes_sum_c = '0;
        no_sum_c  = '0;
        for (int i = 0; i < N_VOTERS; i++) begin
            yes_sum_c = yes_sum_c + CW'(voted_q[i] & ballot_q[i]);
            no_sum_c  = no_sum_c + CW'(voted_q[i] & ~ballot_q[i]);
        end
    end

    // Pass rule evaluated on the latched mode, widened so 3*yes cannot wrap
    always_comb begin
        rule_c = 1'b0;
        case (mode_q)
            2'd0: rule_c = yes_sum_c > no_sum_c;
            2'd1: rule_c = (PW'(2) * PW'(yes_sum_c)) > PW'(N_VOTERS);
            2'd2: rule_c = (PW'(3) * PW'(yes_sum_c)) >= (PW'(2) * PW'(N_VOTERS));
            2'd3: rule_c = yes_sum_c == CW'(N_VOTERS);
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        voted_d   = voted_q;
        ballot_d  = ballot_q;
        mode_d    = mode_q;
        done_d    = 1'b0;
        pass_d    = pass;
        yes_d     = yes_cnt;
        no_d      = no_cnt;
        abstain_d = abstain_cnt;

        case (state_q)
            IDLE, RESULT: begin
                if (start) begin
                    state_d   = VOTING;
                    timer_d   = '0;
                    voted_d   = '0;
                    ballot_d  = '0;
                    mode_d    = mode;
                    pass_d    = 1'b0;
                    yes_d     = '0;
                    no_d      = '0;
                    abstain_d = '0;
                end
            end
            VOTING: begin
                voted_d  = voted_upd_c;
                ballot_d = ballot_upd_c;
                timer_d  = timer_q + TW'(1);
                if ((timer_q == TW'(WINDOW - 1)) || (&voted_upd_c)) begin
                    state_d = TALLY;
                end
            end
            TALLY: begin
                state_d   = RESULT;
                done_d    = 1'b1;
                pass_d    = rule_c;
                yes_d     = yes_sum_c;
                no_d      = no_sum_c;
                abstain_d = CW'(N_VOTERS) - yes_sum_c - no_sum_c;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == VOTING) || (state_d == TALLY);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            voted_q     <= '0;
            ballot_q    <= '0;
            mode_q      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            yes_cnt     <= '0;
            no_cnt      <= '0;
            abstain_cnt <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            voted_q     <= voted_d;
            ballot_q    <= ballot_d;
            mode_q      <= mode_d;
            busy        <= busy_d;
            done        <= done_d;
            pass        <= pass_d;
            yes_cnt     <= yes_d;
            no_cnt      <= no_d;
            abstain_cnt <= abstain_d;
        end
    end

endmodule

// File: tb/tb_voter_seq.sv
// Directed bench for voter_seq: window timing, early close, pass rules, reset and start handling.
module tb_voter_seq;

    localparam int unsigned N   = 7;
    localparam int unsigned W   = 20;
    localparam int unsigned TWB = 16;
    localparam int unsigned CWB = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [1:0]     mode;
    logic [N-1:0]   vote_yes;
    logic [N-1:0]   vote_no;
    logic           busy;
    logic           done;
    logic           pass;
    logic [CWB-1:0] yes_cnt;
    logic [CWB-1:0] no_cnt;
    logic [CWB-1:0] abstain_cnt;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int t0 = 0;

    voter_seq #(.N_VOTERS(N), .WINDOW(W), .TW(TWB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
        .vote_yes   (vote_yes),
        .vote_no    (vote_no),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .yes_cnt    (yes_cnt),
        .no_cnt     (no_cnt),
        .abstain_cnt(abstain_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Latency is counted in rising edges after the edge that samples start:
    // a full window gives W+1, an all-vote-first-cycle ballot gives 2 (3 cycles from start).
    task automatic open_ballot(input logic [1:0] m);
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        t0    = cyc;
    endtask

    task automatic present(input logic [N-1:0] y, input logic [N-1:0] n);
        vote_yes = y;
        vote_no  = n;
        @(negedge clk);
        vote_yes = '0;
        vote_no  = '0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                lat = cyc - t0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic seen;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, pass, yes_cnt, no_cnt, abstain_cnt} !== 12'h000)
            $display("FAIL reset_init: got %h want 000", {busy, done, pass, yes_cnt, no_cnt, abstain_cnt});
        else passed++;
        rst_n = 1'b1;

        open_ballot(2'd0);
        present(7'b0000111, 7'b0011000);
        checks++;
        if (busy !== 1'b1) $display("FAIL busy_in_voting: got %b want 1", busy);
        else passed++;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, pass, yes_cnt, no_cnt, abstain_cnt} !== 12'h000)
            $display("FAIL reset_mid_voting: got %h want 000", {busy, done, pass, yes_cnt, no_cnt, abstain_cnt});
        else passed++;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < W + 5; i++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) $display("FAIL reset_discards_ballot: got activity=%b want 0", seen);
        else passed++;
    endtask

    task automatic test_full_window();
        int lat;
        open_ballot(2'd0);
        present(7'b0000111, 7'b0011000);
        wait_done(lat);
        checks++;
        if (lat !== int'(W + 1)) $display("FAIL full_latency: got %0d want %0d", lat, W + 1);
        else passed++;
        checks++;
        if ({busy, yes_cnt, no_cnt, abstain_cnt, pass} !== {1'b0, 3'd3, 3'd2, 3'd2, 1'b1})
            $display("FAIL full_mode0_pass: got busy/y/n/a/p=%b/%0d/%0d/%0d/%b want 0/3/2/2/1",
                     busy, yes_cnt, no_cnt, abstain_cnt, pass);
        else passed++;
        @(negedge clk);
        checks++;
        if ({done, pass} !== 2'b01) $display("FAIL done_pulse: got done/pass=%b/%b want 0/1", done, pass);
        else passed++;

        open_ballot(2'd0);
        present(7'b0000011, 7'b0011000);
        wait_done(lat);
        checks++;
        if (lat !== int'(W + 1)) $display("FAIL tie_latency: got %0d want %0d", lat, W + 1);
        else passed++;
        checks++;
        if ({yes_cnt, no_cnt, abstain_cnt, pass} !== {3'd2, 3'd2, 3'd3, 1'b0})
            $display("FAIL tie_mode0: got y/n/a/p=%0d/%0d/%0d/%b want 2/2/3/0",
                     yes_cnt, no_cnt, abstain_cnt, pass);
        else passed++;
    endtask

    task automatic test_early_close();
        int lat;
        open_ballot(2'd1);
        present(7'b0001111, 7'b1110000);
        wait_done(lat);
        checks++;
        if (lat !== 2) $display("FAIL early_latency_m1: got %0d want 2", lat);
        else passed++;
        checks++;
        if ({yes_cnt, no_cnt, abstain_cnt, pass} !== {3'd4, 3'd3, 3'd0, 1'b1})
            $display("FAIL early_mode1: got y/n/a/p=%0d/%0d/%0d/%b want 4/3/0/1",
                     yes_cnt, no_cnt, abstain_cnt, pass);
        else passed++;

        open_ballot(2'd2);
        present(7'b0001111, 7'b1110000);
        wait_done(lat);
        checks++;
        if (lat !== 2) $display("FAIL early_latency_m2: got %0d want 2", lat);
        else passed++;
        checks++;
        if ({yes_cnt, no_cnt, pass} !== {3'd4, 3'd3, 1'b0})
            $display("FAIL early_mode2: got y/n/p=%0d/%0d/%b want 4/3/0", yes_cnt, no_cnt, pass);
        else passed++;
    endtask

    task automatic test_conflict();
        int lat;
        open_ballot(2'd0);
        present(7'b0000011, 7'b0000001);
        present(7'b0000000, 7'b0000001);
        present(7'b0000001, 7'b0000000);
        wait_done(lat);
        checks++;
        if (lat !== int'(W + 1)) $display("FAIL conflict_latency: got %0d want %0d", lat, W + 1);
        else passed++;
        checks++;
        if ({yes_cnt, no_cnt, abstain_cnt, pass} !== {3'd1, 3'd1, 3'd5, 1'b0})
            $display("FAIL conflict_no_revote: got y/n/a/p=%0d/%0d/%0d/%b want 1/1/5/0",
                     yes_cnt, no_cnt, abstain_cnt, pass);
        else passed++;
    endtask

    task automatic test_unanimous();
        int lat;
        open_ballot(2'd3);
        present(7'b0111111, 7'b0000000);
        wait_done(lat);
        checks++;
        if (lat !== int'(W + 1)) $display("FAIL unan6_latency: got %0d want %0d", lat, W + 1);
        else passed++;
        checks++;
        if ({yes_cnt, abstain_cnt, pass} !== {3'd6, 3'd1, 1'b0})
            $display("FAIL unan6: got y/a/p=%0d/%0d/%b want 6/1/0", yes_cnt, abstain_cnt, pass);
        else passed++;

        open_ballot(2'd3);
        present(7'b1111111, 7'b0000000);
        wait_done(lat);
        checks++;
        if (lat !== 2) $display("FAIL unan7_latency: got %0d want 2", lat);
        else passed++;
        checks++;
        if ({yes_cnt, no_cnt, abstain_cnt, pass} !== {3'd7, 3'd0, 3'd0, 1'b1})
            $display("FAIL unan7: got y/n/a/p=%0d/%0d/%0d/%b want 7/0/0/1",
                     yes_cnt, no_cnt, abstain_cnt, pass);
        else passed++;
    endtask

    task automatic test_ignore_start();
        int lat;
        open_ballot(2'd0);
        checks++;
        if ({busy, pass, yes_cnt, no_cnt, abstain_cnt} !== {1'b1, 1'b0, 9'd0})
            $display("FAIL start_clears_result: got busy/p/y/n/a=%b/%b/%0d/%0d/%0d want 1/0/0/0/0",
                     busy, pass, yes_cnt, no_cnt, abstain_cnt);
        else passed++;
        present(7'b0000011, 7'b0000100);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            mode  = 2'd3;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
        end
        wait_done(lat);
        checks++;
        if (lat !== int'(W + 1)) $display("FAIL ignore_start_latency: got %0d want %0d", lat, W + 1);
        else passed++;
        checks++;
        if ({yes_cnt, no_cnt, abstain_cnt, pass} !== {3'd2, 3'd1, 3'd4, 1'b1})
            $display("FAIL ignore_mode_change: got y/n/a/p=%0d/%0d/%0d/%b want 2/1/4/1",
                     yes_cnt, no_cnt, abstain_cnt, pass);
        else passed++;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        mode     = 2'd0;
        vote_yes = '0;
        vote_no  = '0;
        test_reset();
        test_full_window();
        test_early_close();
        test_conflict();
        test_unanimous();
        test_ignore_start();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
